// File: rtl/datapath_sequencer.sv
// Program-memory driven sequencer/decoder for the load-store datapath (lw, sw, add, sub, addi).
// Two cycles per instruction (FETCH, EXEC); stall freezes FETCH; halt words end the run, unknown words trap.
module datapath_sequencer #(
  parameter int PROG_DEPTH = 32,
  parameter int PC_W       = $clog2(PROG_DEPTH),
  parameter int REG_ADDR_W = 5,
  parameter int IMM_W      = 12
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  prog_we,
  input  logic [PC_W-1:0]       prog_addr,
  input  logic [31:0]           prog_data,
  input  logic                  start,
  input  logic                  stall,
  output logic                  busy,
  output logic                  done,
  output logic                  illegal,
  output logic [PC_W-1:0]       pc,
  output logic [REG_ADDR_W-1:0] rs1,
  output logic [REG_ADDR_W-1:0] rs2,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [IMM_W-1:0]      immediate,
  output logic                  I_type,
  output logic                  R_type,
  output logic                  sub,
  output logic                  WE_RF,
  output logic                  WE_MEM
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE, S_ERROR} state_t;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [11:0] imm;
    logic        i_type;
    logic        r_type;
    logic        sub;
    logic        we_rf;
    logic        we_mem;
  } fields_t;

  typedef struct packed {
    logic    legal;
    fields_t f;
  } dec_t;

  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_DEPTH - 1);

  function automatic dec_t decode(input logic [31:0] w);
    dec_t d;
    d = '0;
    case (w[6:0])
      7'b0000011: if (w[14:12] == 3'b010) begin
        d.legal = 1'b1; d.f.rd = w[11:7]; d.f.rs1 = w[19:15];
        d.f.imm = w[31:20]; d.f.i_type = 1'b1; d.f.we_rf = 1'b1;
      end
      7'b0100011: if (w[14:12] == 3'b010) begin
        d.legal = 1'b1; d.f.rs1 = w[19:15]; d.f.rs2 = w[24:20];
        d.f.imm = {w[31:25], w[11:7]}; d.f.i_type = 1'b1; d.f.we_mem = 1'b1;
      end
      7'b0110011: if (w[14:12] == 3'b000 && (w[31:25] == 7'b0000000 || w[31:25] == 7'b0100000)) begin
        d.legal = 1'b1; d.f.rd = w[11:7]; d.f.rs1 = w[19:15]; d.f.rs2 = w[24:20];
        d.f.r_type = 1'b1; d.f.we_rf = 1'b1; d.f.sub = w[30];
      end
      7'b0010011: if (w[14:12] == 3'b000) begin
        d.legal = 1'b1; d.f.rd = w[11:7]; d.f.rs1 = w[19:15]; d.f.imm = w[31:20];
        d.f.i_type = 1'b1; d.f.r_type = 1'b1; d.f.we_rf = 1'b1;
      end
      default: ;
    endcase
    return d;
  endfunction

  logic [31:0]     mem [PROG_DEPTH];
  state_t          state, state_nx;
  logic [PC_W-1:0] pc_nx;
  fields_t         ctrl_q;
  logic            load_ctrl;
  logic [31:0]     fetch_word;
  dec_t            fetch_dec;
  logic            is_halt;
  logic            prog_open;

  assign prog_open  = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
  assign fetch_word = mem[pc];
  assign fetch_dec  = decode(fetch_word);
  assign is_halt    = (fetch_word == 32'h0000_0000) || (fetch_word == 32'h0000_0073);

  // Program memory has no reset: contents survive RST and runs.
  always_ff @(posedge CLK) begin
    if (prog_we && prog_open) mem[prog_addr] <= prog_data;
  end

  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    load_ctrl = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_nx = S_FETCH;
          pc_nx    = '0;
        end
      end
      S_FETCH: begin
        if (!stall) begin
          if (is_halt) begin
            state_nx = S_DONE;
          end else if (!fetch_dec.legal) begin
            state_nx = S_ERROR;
          end else begin
            state_nx  = S_EXEC;
            load_ctrl = 1'b1;
          end
        end
      end
      S_EXEC: begin
        if (pc == PC_LAST) begin
          state_nx = S_DONE;
        end else begin
          state_nx = S_FETCH;
          pc_nx    = pc + PC_W'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_IDLE;
      pc     <= '0;
      ctrl_q <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      if (load_ctrl) ctrl_q <= fetch_dec.f;
    end
  end

  // Controls are gated by state so an async reset clears them without waiting for an edge.
  always_comb begin
    busy      = (state == S_FETCH) || (state == S_EXEC);
    done      = (state == S_DONE);
    illegal   = (state == S_ERROR);
    rs1       = '0;
    rs2       = '0;
    rd        = '0;
    immediate = '0;
    I_type    = 1'b0;
    R_type    = 1'b0;
    sub       = 1'b0;
    WE_RF     = 1'b0;
    WE_MEM    = 1'b0;
    if (state == S_EXEC) begin
      rs1       = REG_ADDR_W'(ctrl_q.rs1);
      rs2       = REG_ADDR_W'(ctrl_q.rs2);
      rd        = REG_ADDR_W'(ctrl_q.rd);
      immediate = IMM_W'($signed(ctrl_q.imm));
      I_type    = ctrl_q.i_type;
      R_type    = ctrl_q.r_type;
      sub       = ctrl_q.sub;
      WE_RF     = ctrl_q.we_rf;
      WE_MEM    = ctrl_q.we_mem;
    end
  end

endmodule
